reorder_buf: RTL and testbench

In-order retirement buffer between issue, the reservation station and the store/load buffer. It allocates one entry per issued instruction and hands the entry tag to RS/SLB as the destination tag. It captures execution results from RS and SLB and retires entries strictly in program order. On retirement it writes the register file, broadcasts the value to RS/SLB, releases stores, and flushes the pipeline on control-flow mispredicts.

---
 rtl/reorder_buf.sv | 166 ++++++++++++++++
 tb/tb_reorder_buf.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buf.sv
// In-order retirement buffer: allocates tags at issue, collects RS/SLB results, retires in order.
// Define ROB_BYPASS_EN to forward same-cycle writebacks onto the operand query ports.
module reorder_buf #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4,
    parameter int XLEN     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic [1:0]       alloc_kind,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_pred_taken,
    input  logic [XLEN-1:0]  alloc_alt_pc,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             rs_wb_valid,
    input  logic [TAG_W-1:0] rs_wb_tag,
    input  logic [XLEN-1:0]  rs_wb_value,
    input  logic             rs_wb_jump_valid,
    input  logic [XLEN-1:0]  rs_wb_jumppc,
    input  logic             slb_wb_valid,
    input  logic [TAG_W-1:0] slb_wb_tag,
    input  logic [XLEN-1:0]  slb_wb_value,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q1_value,
    output logic [XLEN-1:0]  q2_value,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [4:0]       commit_rd,
    output logic [XLEN-1:0]  commit_value,
    output logic             commit_wr,
    output logic             commit_store,
    output logic             clear_flag,
    output logic [XLEN-1:0]  redirect_pc
);
    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_BRANCH = 2'd1;
    localparam logic [1:0] KIND_JALR   = 2'd2;
    localparam logic [1:0] KIND_STORE  = 2'd3;
    localparam logic [TAG_W:0] CAP = (TAG_W+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] pred_taken;
    logic [1:0]          kind   [ROB_SIZE];
    logic [4:0]          rd     [ROB_SIZE];
    logic [XLEN-1:0]     alt_pc [ROB_SIZE];
    logic [XLEN-1:0]     value  [ROB_SIZE];
    logic [XLEN-1:0]     jumppc [ROB_SIZE];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic            do_alloc;
    logic            rs_hit;
    logic            slb_hit;
    logic            flush;
    logic [1:0]      head_kind;
    logic [XLEN-1:0] head_value;

    assign alloc_ready = (count < CAP) && !clear_flag;
    assign alloc_tag   = tail;
    assign do_alloc    = rdy && alloc_valid && alloc_ready;

    // Writebacks are dropped while the flush pulse is out.
    assign rs_hit  = rs_wb_valid  && busy[rs_wb_tag]  && !clear_flag;
    assign slb_hit = slb_wb_valid && busy[slb_wb_tag] && !clear_flag;

    assign head_kind    = kind[head];
    assign head_value   = value[head];
    assign commit_valid = rdy && (count != '0) && busy[head] && ready[head] && !clear_flag;
    assign commit_tag   = head;
    assign commit_rd    = commit_valid ? rd[head] : 5'd0;
    assign commit_value = commit_valid ? head_value : '0;
    assign commit_wr    = commit_valid && (head_kind == KIND_REG || head_kind == KIND_JALR)
                          && (rd[head] != 5'd0);
    assign commit_store = commit_valid && (head_kind == KIND_STORE);
    assign flush        = commit_valid && ((head_kind == KIND_JALR) ||
                          (head_kind == KIND_BRANCH && head_value[0] != pred_taken[head]));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            ready       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            clear_flag  <= 1'b0;
            redirect_pc <= '0;
        end else if (rdy) begin
            clear_flag <= flush;
            if (flush) begin
                redirect_pc <= (head_kind == KIND_JALR) ? jumppc[head] : alt_pc[head];
                busy        <= '0;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
            end else begin
                if (rs_hit)  ready[rs_wb_tag]  <= 1'b1;
                if (slb_hit) ready[slb_wb_tag] <= 1'b1;
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + TAG_W'(1);
                end
                if (commit_valid) begin
                    busy[head] <= 1'b0;
                    head       <= head + TAG_W'(1);
                end
                count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(commit_valid);
            end
        end
    end

    // Payload storage; validity is tracked by busy/ready, so no reset here.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            if (rs_hit) begin
                value[rs_wb_tag] <= rs_wb_value;
                if (rs_wb_jump_valid) jumppc[rs_wb_tag] <= rs_wb_jumppc;
            end
            if (slb_hit) value[slb_wb_tag] <= slb_wb_value;
            if (do_alloc) begin
                kind[tail]       <= alloc_kind;
                rd[tail]         <= alloc_rd;
                pred_taken[tail] <= alloc_pred_taken;
                alt_pc[tail]     <= alloc_alt_pc;
            end
        end
    end

    logic [TAG_W-1:0] q_tag [2];
    logic             q_rdy [2];
    logic [XLEN-1:0]  q_val [2];

    assign q_tag[0] = q1_tag;
    assign q_tag[1] = q2_tag;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            q_rdy[i] = busy[q_tag[i]] && ready[q_tag[i]];
            q_val[i] = q_rdy[i] ? value[q_tag[i]] : '0;
`ifdef ROB_BYPASS_EN
            if (slb_hit && slb_wb_tag == q_tag[i]) begin
                q_rdy[i] = 1'b1;
                q_val[i] = slb_wb_value;
            end else if (rs_hit && rs_wb_tag == q_tag[i]) begin
                q_rdy[i] = 1'b1;
                q_val[i] = rs_wb_value;
            end
`else
`endif
        end
    end

    assign q1_ready = q_rdy[0];
    assign q2_ready = q_rdy[1];
    assign q1_value = q_val[0];
    assign q2_value = q_val[1];
endmodule

// File: tb/tb_reorder_buf.sv
// Directed self-checking bench for reorder_buf; expected values are hand-computed per scenario.
module tb_reorder_buf;
    localparam int TAG_W = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             alloc_valid;
    logic [1:0]       alloc_kind;
    logic [4:0]       alloc_rd;
    logic             alloc_pred_taken;
    logic [XLEN-1:0]  alloc_alt_pc;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             rs_wb_valid;
    logic [TAG_W-1:0] rs_wb_tag;
    logic [XLEN-1:0]  rs_wb_value;
    logic             rs_wb_jump_valid;
    logic [XLEN-1:0]  rs_wb_jumppc;
    logic             slb_wb_valid;
    logic [TAG_W-1:0] slb_wb_tag;
    logic [XLEN-1:0]  slb_wb_value;
    logic [TAG_W-1:0] q1_tag;
    logic [TAG_W-1:0] q2_tag;
    logic             q1_ready;
    logic             q2_ready;
    logic [XLEN-1:0]  q1_value;
    logic [XLEN-1:0]  q2_value;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_tag;
    logic [4:0]       commit_rd;
    logic [XLEN-1:0]  commit_value;
    logic             commit_wr;
    logic             commit_store;
    logic             clear_flag;
    logic [XLEN-1:0]  redirect_pc;

    int checks = 0;
    int failures = 0;

    reorder_buf #(.ROB_SIZE(16), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
        .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .rs_wb_valid(rs_wb_valid), .rs_wb_tag(rs_wb_tag), .rs_wb_value(rs_wb_value),
        .rs_wb_jump_valid(rs_wb_jump_valid), .rs_wb_jumppc(rs_wb_jumppc),
        .slb_wb_valid(slb_wb_valid), .slb_wb_tag(slb_wb_tag), .slb_wb_value(slb_wb_value),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_wr(commit_wr), .commit_store(commit_store),
        .clear_flag(clear_flag), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid      = 1'b0;
        rs_wb_valid      = 1'b0;
        rs_wb_jump_valid = 1'b0;
        slb_wb_valid     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] k, input logic [4:0] r, input logic p,
                         input logic [31:0] a);
        alloc_valid      = 1'b1;
        alloc_kind       = k;
        alloc_rd         = r;
        alloc_pred_taken = p;
        alloc_alt_pc     = a;
        step();
        alloc_valid      = 1'b0;
    endtask

    task automatic rs_drive(input logic [3:0] t, input logic [31:0] v);
        rs_wb_valid = 1'b1;
        rs_wb_tag   = t;
        rs_wb_value = v;
    endtask

    task automatic slb_drive(input logic [3:0] t, input logic [31:0] v);
        slb_wb_valid = 1'b1;
        slb_wb_tag   = t;
        slb_wb_value = v;
    endtask

    initial begin
        rdy = 1'b1;
        alloc_kind = 2'd0; alloc_rd = 5'd0; alloc_pred_taken = 1'b0; alloc_alt_pc = '0;
        rs_wb_tag = '0; rs_wb_value = '0; rs_wb_jumppc = '0;
        slb_wb_tag = '0; slb_wb_value = '0;
        q1_tag = '0; q2_tag = '0;
        do_reset();

        // Reset state
        #1;
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_wr", commit_wr, 0);
        check("rst_commit_store", commit_store, 0);
        check("rst_clear_flag", clear_flag, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_q1_ready", q1_ready, 0);
        check("rst_q1_value", q1_value, 0);

        // Fill 16 entries, 17th request ignored
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'(i + 1);
            #1;
            check("fill_tag", alloc_tag, i);
            check("fill_ready", alloc_ready, 1);
            step();
        end
        #1;
        check("full_ready", alloc_ready, 0);
        step();
        alloc_valid = 1'b0;
        #1;
        check("ignored_alloc_tag", alloc_tag, 0);
        check("ignored_alloc_ready", alloc_ready, 0);
        check("full_no_commit", commit_valid, 0);

        // Wrap: commit while full blocks allocation, then the freed slot is tag 0
        rs_drive(4'd0, 32'h55);
        step();
        idle();
        alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'd9;
        #1;
        check("wrap_commit_valid", commit_valid, 1);
        check("wrap_commit_tag", commit_tag, 0);
        check("wrap_commit_value", commit_value, 32'h55);
        check("wrap_full_ready", alloc_ready, 0);
        step();
        check("wrap_ready_after", alloc_ready, 1);
        check("wrap_tag_after", alloc_tag, 0);
        step();
        alloc_valid = 1'b0;
        #1;
        check("wrap_refull_ready", alloc_ready, 0);
        check("wrap_refull_tag", alloc_tag, 1);

        // Out-of-order writeback, in-order commit
        do_reset();
        alloc(2'd0, 5'd1, 1'b0, 32'h0);
        alloc(2'd0, 5'd2, 1'b0, 32'h0);
        alloc(2'd0, 5'd3, 1'b0, 32'h0);
        rs_drive(4'd2, 32'h11);
        step();
        idle();
        slb_drive(4'd1, 32'h22);
        #1;
        check("ooo_wait", commit_valid, 0);
        step();
        idle();
        rs_drive(4'd0, 32'h33);
        step();
        idle();
        alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'd0;
        #1;
        check("ooo_c0_valid", commit_valid, 1);
        check("ooo_c0_tag", commit_tag, 0);
        check("ooo_c0_value", commit_value, 32'h33);
        check("ooo_c0_rd", commit_rd, 1);
        check("ooo_c0_wr", commit_wr, 1);
        check("ooo_alloc_tag3", alloc_tag, 3);
        step();
        alloc_valid = 1'b0;
        #1;
        check("ooo_c1_tag", commit_tag, 1);
        check("ooo_c1_value", commit_value, 32'h22);
        check("ooo_alloc_tag4", alloc_tag, 4);
        step();
        q1_tag = 4'd3;
        check("ooo_c2_tag", commit_tag, 2);
        check("ooo_c2_value", commit_value, 32'h11);
        check("ooo_q3_not_ready", q1_ready, 0);
        rs_drive(4'd3, 32'h99);
        slb_drive(4'd3, 32'h77);
        step();
        idle();
        #1;
        check("prio_commit_valid", commit_valid, 1);
        check("prio_slb_wins", commit_value, 32'h77);
        check("rd0_no_wr", commit_wr, 0);
        check("prio_q_ready", q1_ready, 1);
        check("prio_q_value", q1_value, 32'h77);
        rs_drive(4'd9, 32'hEE);
        step();
        idle();
        q1_tag = 4'd9;
        #1;
        check("nonbusy_wb_ignored", q1_ready, 0);
        check("empty_no_commit", commit_valid, 0);
        check("empty_alloc_tag", alloc_tag, 4);

        // Branch mispredict flushes younger entries
        do_reset();
        alloc(2'd1, 5'd0, 1'b1, 32'h1004);
        alloc(2'd0, 5'd5, 1'b0, 32'h0);
        alloc(2'd0, 5'd6, 1'b0, 32'h0);
        alloc(2'd0, 5'd7, 1'b0, 32'h0);
        rs_drive(4'd1, 32'hA1);
        slb_drive(4'd2, 32'hA2);
        step();
        idle();
        rs_drive(4'd3, 32'hA3);
        step();
        idle();
        rs_drive(4'd0, 32'h0);
        step();
        idle();
        #1;
        check("br_commit_valid", commit_valid, 1);
        check("br_commit_tag", commit_tag, 0);
        check("br_commit_wr", commit_wr, 0);
        check("br_clear_early", clear_flag, 0);
        step();
        alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'd8;
        #1;
        check("br_clear_flag", clear_flag, 1);
        check("br_redirect_pc", redirect_pc, 32'h1004);
        check("br_clear_no_commit", commit_valid, 0);
        check("br_clear_alloc_ready", alloc_ready, 0);
        step();
        alloc_valid = 1'b0;
        q1_tag = 4'd1;
        #1;
        check("br_clear_falls", clear_flag, 0);
        check("br_young_flushed", commit_valid, 0);
        check("br_tail_reset", alloc_tag, 0);
        check("br_ready_after", alloc_ready, 1);
        check("br_q_flushed", q1_ready, 0);

        // Correctly predicted branch does not flush
        alloc(2'd1, 5'd0, 1'b0, 32'h2000);
        rs_drive(4'd0, 32'h0);
        step();
        idle();
        #1;
        check("brok_commit_valid", commit_valid, 1);
        step();
        check("brok_no_clear", clear_flag, 0);
        check("brok_alloc_tag", alloc_tag, 1);

        // JALR writes link register and redirects
        alloc(2'd2, 5'd1, 1'b0, 32'h0);
        rs_drive(4'd1, 32'h2008);
        rs_wb_jump_valid = 1'b1;
        rs_wb_jumppc = 32'h3000;
        step();
        idle();
        #1;
        check("jalr_commit_valid", commit_valid, 1);
        check("jalr_commit_tag", commit_tag, 1);
        check("jalr_commit_wr", commit_wr, 1);
        check("jalr_commit_rd", commit_rd, 1);
        check("jalr_commit_value", commit_value, 32'h2008);
        step();
        check("jalr_clear_flag", clear_flag, 1);
        check("jalr_redirect_pc", redirect_pc, 32'h3000);
        step();
        check("jalr_clear_falls", clear_flag, 0);

        // rdy low freezes everything
        alloc(2'd0, 5'd4, 1'b0, 32'h0);
        rs_drive(4'd0, 32'h44);
        step();
        idle();
        rdy = 1'b0;
        alloc_valid = 1'b1;
        #1;
        check("stall_no_commit", commit_valid, 0);
        step();
        alloc_valid = 1'b0;
        rdy = 1'b1;
        #1;
        check("stall_commit_resumes", commit_valid, 1);
        check("stall_commit_value", commit_value, 32'h44);
        check("stall_tail_frozen", alloc_tag, 1);
        step();
        check("stall_drained", commit_valid, 0);

        // Query bypass and store commit
        do_reset();
        alloc(2'd3, 5'd0, 1'b0, 32'h0);
        for (int i = 1; i < 6; i++) alloc(2'd0, 5'(i + 10), 1'b0, 32'h0);
        q1_tag = 4'd5;
        q2_tag = 4'd5;
        rs_drive(4'd5, 32'hAB);
        #1;
`ifdef ROB_BYPASS_EN
        check("byp_same_ready", q1_ready, 1);
        check("byp_same_value", q1_value, 32'hAB);
`else
        check("byp_same_ready", q1_ready, 0);
`endif
        step();
        idle();
        #1;
        check("byp_next_q1_ready", q1_ready, 1);
        check("byp_next_q1_value", q1_value, 32'hAB);
        check("byp_next_q2_ready", q2_ready, 1);
        check("byp_next_q2_value", q2_value, 32'hAB);
        slb_drive(4'd0, 32'h1000);
        step();
        idle();
        #1;
        check("store_commit_valid", commit_valid, 1);
        check("store_commit_store", commit_store, 1);
        check("store_commit_wr", commit_wr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
